// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I hazard controller: FSM state codes,
// forwarding-select codes, the stage control bundle and the forwarding helper.
package pipe_ctrl_defs;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result

  // Enables and clears for every pipeline register, as one bundle.
  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic clr_d;
    logic clr_e;
  } ctrl_t;

  localparam ctrl_t CTRL_FLOW = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1,
                                  en_w: 1'b1, clr_d: 1'b0, clr_e: 1'b0};

  // Forwarding select for one E-stage source; the younger M result wins over W,
  // and x0 is never forwarded because it always reads as zero.
  function automatic logic [1:0] fwd_sel(input logic       regwrite_m,
                                         input logic [4:0] rd_m,
                                         input logic       regwrite_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs))      return FWD_M;
    else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
    else                                                   return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count events, sticking at the maximum instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (inc && (cnt != '1))    cnt <= cnt + ONE;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline.
// Produces stage enables/clears, E-stage forwarding selects, a sticky
// data-memory timeout fault and two saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_defs::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             load_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             pcsrc_e,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             clr_d,
  output logic             clr_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

  state_e            r_state, w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt,  w_wcnt_nxt;
  logic              w_lu, w_mw, w_flush;
  ctrl_t             w_ctrl;

  // Hazard detection: load-use against D sources, and an unfinished dmem access in M.
  always_comb begin
    w_lu = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    w_mw = dmem_req_m && !dmem_ready;
  end

  // Forwarding selects; forced to register-file while reset is held.
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (rst_n) begin
      fwd_a_e = fwd_sel(regwrite_m, rd_m, regwrite_w, rd_w, rs1_e);
      fwd_b_e = fwd_sel(regwrite_m, rd_m, regwrite_w, rd_w, rs2_e);
    end
  end

  // Priority mux FAULT > mem wait > taken branch > load-use > free flow.
  // A mem wait holds E, so any branch or load-use there is re-seen after release.
  always_comb begin
    w_ctrl  = CTRL_FLOW;
    w_flush = 1'b0;
    if (!rst_n) begin
      w_ctrl = CTRL_FLOW;
    end else if (r_state == ST_FAULT) begin
      w_ctrl = '0;
    end else if (w_mw) begin
      // W keeps moving so the instruction ahead of M retires; the datapath
      // gates W regwrite while M is held, so W sees a bubble.
      w_ctrl.en_f = 1'b0;
      w_ctrl.en_d = 1'b0;
      w_ctrl.en_e = 1'b0;
      w_ctrl.en_m = 1'b0;
    end else if (pcsrc_e) begin
      // Wrong-path instructions in D and E are squashed, which also kills
      // any load-use hazard the D instruction would have raised.
      w_ctrl.clr_d = 1'b1;
      w_ctrl.clr_e = 1'b1;
      w_flush      = 1'b1;
    end else if (w_lu) begin
      w_ctrl.en_f  = 1'b0;
      w_ctrl.en_d  = 1'b0;
      w_ctrl.clr_e = 1'b1;
    end
  end

  always_comb begin
    en_f      = w_ctrl.en_f;
    en_d      = w_ctrl.en_d;
    en_e      = w_ctrl.en_e;
    en_m      = w_ctrl.en_m;
    en_w      = w_ctrl.en_w;
    clr_d     = w_ctrl.clr_d;
    clr_e     = w_ctrl.clr_e;
    mem_fault = (r_state == ST_FAULT);
  end

  // Next state: count consecutive wait cycles; the last allowed one with the
  // access still pending trips the fault. Ready releases in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_RUN: begin
        if (w_mw) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wcnt_nxt  = WCNT_ONE;
        end else begin
          w_wcnt_nxt  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!w_mw) begin
          w_state_nxt = ST_RUN;
          w_wcnt_nxt  = '0;
        end else if (r_wcnt == WCNT_LAST) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_wcnt_nxt  = r_wcnt + WCNT_ONE;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // FSM state and wait counter; reset returns to RUN from anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!w_ctrl.en_f),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush),
    .cnt   (flush_cnt)
  );

endmodule
